beat_gather: RTL

Downstream consumer of `in_buff`: collects four consecutive 8-lane beats from `in_buff`'s `out_data_0..7`/`out_data_valid` stream and reassembles them into one 32-word frame. It presents the frame on registered outputs with a one-cycle frame-valid pulse. It also tracks partial-frame status and a running frame count for the SFU control path.

---
 rtl/beat_gather_pkg.sv | 17 +
 rtl/beat_gather_if.sv | 28 ++
 rtl/beat_gather_stage_mem.sv | 32 +++
 rtl/beat_gather.sv | 71 +++++++
 4 files changed

// File: rtl/beat_gather_pkg.sv
// Shared SFU constants and types for the 8-lane beat stream and 32-word frame.
package sfu_pkg;

  localparam int SFU_DW      = 32;
  localparam int LANES       = 8;
  localparam int BEATS       = 4;
  localparam int FRAME_WORDS = LANES * BEATS;
  localparam int FCNT_W      = 16;

  // The final beat goes straight to the output registers, so only the
  // first BEATS-1 beats need staging.
  localparam int STAGE_SLOTS = BEATS - 1;
  localparam int STAGE_WORDS = STAGE_SLOTS * LANES;

  typedef logic [SFU_DW-1:0] sfu_word_t;

endpackage

// File: rtl/beat_gather_if.sv
// Beat stream in, assembled frame and status out.
interface beat_gather_if
  import sfu_pkg::*;
#(
  parameter int DW = 32
);

  logic          enable;
  logic          flush;
  logic [DW-1:0] in_data [LANES];
  logic          in_data_valid;

  logic [DW-1:0]     out_data [FRAME_WORDS];
  logic              out_data_valid;
  logic              partial;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output enable, flush, in_data, in_data_valid,
    input  out_data, out_data_valid, partial, frame_cnt
  );

  modport slave (
    input  enable, flush, in_data, in_data_valid,
    output out_data, out_data_valid, partial, frame_cnt
  );

endinterface

// File: rtl/beat_gather_stage_mem.sv
// Staging register file: holds beats 0..2 of the frame being gathered.
module beat_stage_mem
  import sfu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    slot,
  input  logic [DW-1:0] wr_data [LANES],
  output logic [DW-1:0] rd_data [STAGE_WORDS]
);

  logic [DW-1:0] mem_q [STAGE_WORDS];

  // Write all eight lanes of a beat into the addressed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGE_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int s = 0; s < STAGE_SLOTS; s++) begin
        if (slot == 2'(s)) begin
          for (int l = 0; l < LANES; l++) mem_q[s*LANES + l] <= wr_data[l];
        end
      end
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/beat_gather.sv
// Gathers four 8-lane beats into one registered 32-word frame with a
// one-cycle valid pulse, partial-frame flag and wrapping frame count.
module beat_gather
  import sfu_pkg::*;
#(
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rst,
  beat_gather_if.slave bus
);

  logic [1:0]        bcnt_q, bcnt_d;
  logic              accept, complete;
  logic              partial_q;
  logic              valid_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [DW-1:0]     out_q   [FRAME_WORDS];
  logic [DW-1:0]     stage_w [STAGE_WORDS];

  // Beat qualification and next slot; flush beats any beat in the same cycle.
  always_comb begin
    accept   = bus.enable & bus.in_data_valid & ~bus.flush;
    complete = accept & (bcnt_q == 2'd3);
    bcnt_d   = bcnt_q;
    if (bus.enable && bus.flush) bcnt_d = 2'd0;
    else if (accept)             bcnt_d = bcnt_q + 2'd1;
  end

  beat_stage_mem #(.DW(DW)) u_stage (
    .clk     (clk),
    .rst     (rst),
    .we      (accept & ~complete),
    .slot    (bcnt_q),
    .wr_data (bus.in_data),
    .rd_data (stage_w)
  );

  // Beat counter and the registered partial-frame flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q    <= 2'd0;
      partial_q <= 1'b0;
    end else begin
      bcnt_q    <= bcnt_d;
      partial_q <= (bcnt_d != 2'd0);
    end
  end

  // Frame output registers, valid pulse and frame counter; all load on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_WORDS; i++) out_q[i] <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      valid_q <= complete;
      if (complete) begin
        for (int i = 0; i < STAGE_WORDS; i++) out_q[i] <= stage_w[i];
        for (int l = 0; l < LANES; l++) out_q[STAGE_WORDS + l] <= bus.in_data[l];
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  assign bus.out_data       = out_q;
  assign bus.out_data_valid = valid_q;
  assign bus.partial        = partial_q;
  assign bus.frame_cnt      = frame_cnt_q;

endmodule
